// File: rtl/uart_sha_pkg.sv
// Shared types and constants for the UART-to-SHA-256 block loader.
package uart_sha_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        HOLD    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_CMD     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;

    localparam int unsigned CMD_FIRST_BIT = 0;
    localparam int unsigned CMD_LAST_BIT  = 1;

    // Only the two flag bits may be set in a command byte.
    function automatic logic cmd_is_valid(input logic [7:0] cmd);
        return cmd[7:2] == 6'd0;
    endfunction

endpackage

// File: rtl/uart_sha_block_loader_timeout.sv
// Inter-byte watchdog: counts idle clocks and flags the last allowed one.
module uart_sha_timeout #(
    parameter int unsigned TIMEOUT_CLKS = 2048,
    parameter int unsigned CNT_W        = 16
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire_c = (cnt == CNT_W'(TIMEOUT_CLKS - 1));

endmodule

// File: rtl/uart_sha_block_loader.sv
// Parses sync/command/payload frames from the UART receiver into SHA-256 blocks.
// Define UART_SHA_LOADER_CSUM_EN to require a trailing XOR checksum byte per frame.
module uart_sha_block_loader
    import uart_sha_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned BLOCK_BYTES  = 64,
    parameter int unsigned TIMEOUT_CLKS = 2048,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                     i_Clock,
    input  logic                     i_Rst_n,
    input  logic                     i_Rx_DV,
    input  logic [7:0]               i_Rx_Byte,
    output logic                     o_Block_Valid,
    input  logic                     i_Block_Ready,
    output logic [BLOCK_BYTES*8-1:0] o_Block,
    output logic                     o_First,
    output logic                     o_Last,
    output logic                     o_Busy,
    output logic                     o_Err,
    output logic [1:0]               o_Err_Code
);

    localparam int unsigned IDX_W = $clog2(BLOCK_BYTES);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] lane_c;
    logic             timing_c;
    logic             to_clr_c;
    logic             to_en_c;
    logic             expire_c;
    logic             timeout_c;
`ifdef UART_SHA_LOADER_CSUM_EN
    logic [7:0]       csum;
`endif

    // Watchdog only runs while a frame is in flight; any byte restarts it.
    assign timing_c  = (state == CMD) || (state == PAYLOAD) || (state == CSUM);
    assign to_clr_c  = !timing_c || i_Rx_DV;
    assign to_en_c   = timing_c && !i_Rx_DV && !expire_c;
    assign timeout_c = timing_c && !i_Rx_DV && expire_c;

    // Payload byte 0 lands in the most significant lane.
    assign lane_c = IDX_W'(BLOCK_BYTES - 1) - idx;

    uart_sha_timeout #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS),
        .CNT_W       (CNT_W)
    ) u_timeout (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .clr     (to_clr_c),
        .en      (to_en_c),
        .expire_c(expire_c)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            o_Block_Valid <= 1'b0;
            o_Block       <= '0;
            o_First       <= 1'b0;
            o_Last        <= 1'b0;
            o_Busy        <= 1'b0;
            o_Err         <= 1'b0;
            o_Err_Code    <= 2'd0;
`ifdef UART_SHA_LOADER_CSUM_EN
            csum          <= 8'd0;
`endif
        end else begin
            o_Err <= 1'b0;
            if (timeout_c) begin
                state      <= IDLE;
                o_Busy     <= 1'b0;
                o_Err      <= 1'b1;
                o_Err_Code <= ERR_TIMEOUT;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                            state  <= CMD;
                            o_Busy <= 1'b1;
                        end
                    end
                    CMD: begin
                        if (i_Rx_DV) begin
                            if (cmd_is_valid(i_Rx_Byte)) begin
                                o_First <= i_Rx_Byte[CMD_FIRST_BIT];
                                o_Last  <= i_Rx_Byte[CMD_LAST_BIT];
                                idx     <= '0;
`ifdef UART_SHA_LOADER_CSUM_EN
                                csum    <= 8'd0;
`endif
                                state   <= PAYLOAD;
                            end else begin
                                state      <= IDLE;
                                o_Busy     <= 1'b0;
                                o_Err      <= 1'b1;
                                o_Err_Code <= ERR_CMD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (i_Rx_DV) begin
                            o_Block[{lane_c, 3'b000} +: 8] <= i_Rx_Byte;
                            idx <= idx + IDX_W'(1);
`ifdef UART_SHA_LOADER_CSUM_EN
                            csum <= csum ^ i_Rx_Byte;
                            if (idx == IDX_W'(BLOCK_BYTES - 1)) begin
                                state <= CSUM;
                            end
`else
                            if (idx == IDX_W'(BLOCK_BYTES - 1)) begin
                                state         <= HOLD;
                                o_Block_Valid <= 1'b1;
                            end
`endif
                        end
                    end
                    CSUM: begin
`ifdef UART_SHA_LOADER_CSUM_EN
                        if (i_Rx_DV) begin
                            if (i_Rx_Byte == csum) begin
                                state         <= HOLD;
                                o_Block_Valid <= 1'b1;
                            end else begin
                                state      <= IDLE;
                                o_Busy     <= 1'b0;
                                o_Err      <= 1'b1;
                                o_Err_Code <= ERR_CSUM;
                            end
                        end
`else
                        state  <= IDLE;
                        o_Busy <= 1'b0;
`endif
                    end
                    HOLD: begin
                        if (i_Block_Ready) begin
                            state         <= IDLE;
                            o_Block_Valid <= 1'b0;
                            o_Busy        <= 1'b0;
                        end
                        // A byte here has nowhere to go; the block being offered is kept intact.
                        if (i_Rx_DV) begin
                            o_Err      <= 1'b1;
                            o_Err_Code <= ERR_OVERRUN;
                        end
                    end
                    default: begin
                        state         <= IDLE;
                        o_Block_Valid <= 1'b0;
                        o_Busy        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_sha_block_loader.md
Name: uart_sha_block_loader

Overview:
- Sequences the UART receive datapath into SHA-256 message blocks.
- Consumes the single-cycle byte strobes from the UART receiver and parses a framed protocol: sync byte, command byte, then BLOCK_BYTES payload bytes.
- Assembles the payload big-endian into one 512-bit block and hands it to the SHA core over a valid/ready handshake, along with first/last-block flags.
- Detects inter-byte timeout, overrun and malformed frames.

Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.
- BLOCK_BYTES, 64: payload bytes per frame; o_Block width = BLOCK_BYTES*8.
- TIMEOUT_CLKS, 2048: maximum clocks allowed between bytes inside a frame. Must be greater than 870, which is about one byte time at 87 clocks per bit.
- CNT_W, 16: timeout counter width. Must satisfy 2^CNT_W > TIMEOUT_CLKS.

Ports:
- i_Clock  in  1  system clock; all logic rises on the positive edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Rx_DV  in  1  byte-valid strobe from the UART receiver; one cycle wide.
- i_Rx_Byte  in  8  received byte; valid only while i_Rx_DV=1.
- o_Block_Valid  out  1  assembled block available.
- i_Block_Ready  in  1  SHA core accepts the block.
- o_Block  out  BLOCK_BYTES*8  message block; payload byte 0 sits in bits [511:504].
- o_First  out  1  block starts a new message (command bit0).
- o_Last  out  1  block ends the message (command bit1).
- o_Busy  out  1  high in every state except IDLE.
- o_Err  out  1  one-cycle error pulse.
- o_Err_Code  out  2  error cause, valid while o_Err=1: 0 bad command, 1 timeout, 2 overrun, 3 checksum.

Behaviour:
- Reset (asynchronous, i_Rst_n=0): state=IDLE, byte index=0, timeout counter=0. All outputs are 0, including o_Block. Asserting reset mid-frame or during HOLD discards the frame with no error pulse.
- A byte is consumed only on a cycle with i_Rx_DV=1. i_Rx_Byte is ignored otherwise.
- IDLE: on a byte equal to SYNC_BYTE, go to CMD. Any other byte is silently discarded.
- CMD: on a byte, capture bit0 into the first flag and bit1 into the last flag.
  - If bits[7:2]=0, clear the byte index and go to PAYLOAD.
  - Otherwise pulse o_Err with code 0 and go to IDLE.
- PAYLOAD: on each byte, write it to o_Block[511-8*idx -: 8] and increment idx.
  - On the byte with idx=BLOCK_BYTES-1, go to HOLD (or CSUM when the optional feature is enabled).
  - Bytes not yet written keep the previous block's value; the bench must not rely on them.
- HOLD:
  - o_Block_Valid=1; o_Block, o_First and o_Last are held stable.
  - A transfer occurs on the cycle where o_Block_Valid and i_Block_Ready are both 1. The next state is IDLE and o_Block_Valid returns to 0 the following cycle.
  - i_Block_Ready is ignored outside HOLD.
  - A byte arriving in HOLD is dropped and pulses o_Err with code 2; the state stays HOLD.
  - If that byte arrives on the same cycle as the transfer, the transfer completes and the overrun is still flagged.
- Latency: o_Block_Valid rises on the cycle after the final payload (or checksum) byte's DV cycle.
- Timeout (applies in CMD, PAYLOAD and CSUM):
  - The counter clears on entry to each of these states and on every consumed byte, and increments otherwise.
  - When it reaches TIMEOUT_CLKS-1 with no byte present, go to IDLE and pulse o_Err with code 1.
  - A byte arriving on the threshold cycle wins over the timeout.
  - The counter is frozen at 0 in IDLE and HOLD.
- o_Err is registered. Only one cause can occur per cycle, so there is no priority conflict.
- o_First and o_Last are updated only in CMD and hold their value until the next accepted command.

Optional Feature:
- Macro: UART_SHA_LOADER_CSUM_EN.
- With the macro defined:
  - A running XOR of the payload bytes is kept, cleared on entry to PAYLOAD.
  - A CSUM state follows the last payload byte and expects one checksum byte.
  - Match → HOLD. Mismatch → pulse o_Err with code 3 and go to IDLE; o_Block_Valid is never raised.
- Without the macro: no CSUM state and no XOR register; PAYLOAD goes directly to HOLD, and code 3 never occurs.

Decomposition:
- Package uart_sha_pkg holds:
  - the state enum (IDLE, CMD, PAYLOAD, CSUM, HOLD);
  - the error-code localparams ERR_CMD=2'd0, ERR_TIMEOUT=2'd1, ERR_OVERRUN=2'd2, ERR_CSUM=2'd3;
  - the command bit positions CMD_FIRST_BIT=0 and CMD_LAST_BIT=1.
- One sub-module, uart_sha_timeout: a CNT_W-bit counter with clear and enable inputs and an expire output.

Test Plan:
- Full frame: send A5, 03, bytes 00..3F, then hold i_Block_Ready=1 → o_Block_Valid rises 1 cycle after byte 3F; o_Block[511:480]=32'h00010203, [31:0]=32'h3C3D3E3F; o_First=o_Last=1; the state returns to IDLE one cycle after the transfer.
- Backpressure/overrun: hold i_Block_Ready=0 for 2000 clocks and inject byte 55 → o_Block stays constant; o_Err pulses once with code 2; after Ready=1 the block transfers once.
- Timeout: send A5, 01, then 10 bytes, then idle for 2048 clocks → o_Err with code 1 at count 2047; o_Busy=0 afterwards; o_Block_Valid never rises.
- Bad command and noise: send 7E, 11, A5, 04 → 7E and 11 are ignored; 04 gives o_Err with code 0; a following valid frame is accepted normally.
- Reset mid-frame: pull i_Rst_n low after 30 payload bytes → all outputs are 0 immediately (asynchronously); a fresh frame after reset release completes.
- With CSUM_EN: payload of 64 bytes of 5A plus checksum 00 → block delivered; checksum 01 → o_Err with code 3 and no o_Block_Valid.
